// File: rtl/cic_decim_if.sv
// Sample stream bundle for the CIC decimator.
// Ports: val_in/i_data (high-rate samples in), val_out/o_data (decimated out).
interface cic_decim_if #(
    parameter int Win  = 16,
    parameter int Wout = 16
);
    logic                   val_in;
    logic signed [Win-1:0]  i_data;
    logic                   val_out;
    logic signed [Wout-1:0] o_data;

    modport master (
        output val_in,
        output i_data,
        input  val_out,
        input  o_data
    );

    modport slave (
        input  val_in,
        input  i_data,
        output val_out,
        output o_data
    );
endinterface

// File: rtl/cic_decim.sv
// Three-stage CIC decimator: 3 integrators, decimate by R, 3 combs (M=1).
// Ports: clk, rst (sync, active-low), bus (slave side of cic_decim_if).
module cic_decim #(
    parameter int Win  = 16,
    parameter int Wg   = 9,
    parameter int R    = 8,
    parameter int Wout = 16
) (
    input  logic     clk,
    input  logic     rst,
    cic_decim_if.slave bus
);
    localparam int W  = Win + Wg;
    localparam int CW = $clog2(R);

    typedef logic signed [W-1:0] word_t;

    word_t          din;
    word_t          acc [3];
    logic [2:0]     iv;
    word_t          dec;
    logic           vd;
    logic [CW-1:0]  cnt;
    word_t          prev [3];
    word_t          y [3];
    logic [2:0]     cv;
    word_t          cx [3];
    logic [2:0]     cin_v;

    assign din = {{Wg{bus.i_data[Win-1]}}, bus.i_data};

    // Integrators run at the input rate; wrap-around is intentional.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) acc[k] <= '0;
            iv <= '0;
        end else begin
            iv <= {iv[1:0], bus.val_in};
            if (bus.val_in) acc[0] <= acc[0] + din;
            if (iv[0])      acc[1] <= acc[1] + acc[0];
            if (iv[1])      acc[2] <= acc[2] + acc[1];
        end
    end

    // Keep every R-th integrator output; phase 0 is the R-th valid sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dec <= '0;
            vd  <= 1'b0;
            cnt <= '0;
        end else begin
            vd <= 1'b0;
            if (iv[2]) begin
                if (cnt == CW'(R - 1)) begin
                    dec <= acc[2];
                    vd  <= 1'b1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign cx[0] = dec;
    assign cx[1] = y[0];
    assign cx[2] = y[1];
    assign cin_v = {cv[1:0], vd};

    // Combs run at the low rate, one differential delay each.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                prev[k] <= '0;
                y[k]    <= '0;
            end
            cv <= '0;
        end else begin
            cv <= cin_v;
            for (int k = 0; k < 3; k++) begin
                if (cin_v[k]) begin
                    y[k]    <= cx[k] - prev[k];
                    prev[k] <= cx[k];
                end
            end
        end
    end

    assign bus.val_out = cv[2];
    assign bus.o_data  = y[2][W-1 -: Wout];
endmodule

// File: tb/tb_cic_decim.sv
// Self-checking bench for cic_decim (Win=16, Wg=9, R=8, Wout=16).
// Reference: FIR of three cascaded R-boxcars, modulo 2^25, truncated.
module tb_cic_decim;
    localparam int R = 8;
    localparam int N = 22;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cic_decim_if #(.Win(16), .Wout(16)) bus ();

    cic_decim #(
        .Win(16), .Wg(9), .R(8), .Wout(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int din;
        int gap;
        int nout;
        int steady;
    } vec_t;

    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    longint h [N];
    longint hist [$];
    int     pend [int];
    int     hold  = 0;
    int     outs [$];
    int     pcyc [$];
    int     dc_ref [$];

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic void build_h();
        longint b [N];
        longint c [N];
        foreach (b[k]) b[k] = 0;
        b[0] = 1;
        repeat (3) begin
            foreach (c[k]) begin
                c[k] = 0;
                for (int j = 0; j < R; j++)
                    if (k - j >= 0) c[k] += b[k-j];
            end
            b = c;
        end
        h = b;
    endfunction

    function automatic int model_out();
        longint            acc;
        int                n;
        logic [63:0]       u;
        logic [24:0]       m;
        logic signed [15:0] o;
        acc = 0;
        n = hist.size();
        for (int k = 0; k < N; k++)
            if (n - 1 - k >= 0) acc += h[k] * hist[n-1-k];
        u = acc;
        m = u[24:0];
        o = $signed(m[24:9]);
        return int'(o);
    endfunction

    task automatic step(input logic v, input int d);
        bus.val_in = v;
        bus.i_data = 16'(d);
        @(posedge clk);
        cyc++;
        if (!rst) begin
            hist.delete();
            pend.delete();
            hold = 0;
        end else if (v) begin
            hist.push_back(longint'(d));
            if (hist.size() % R == 0) pend[cyc+6] = model_out();
        end
        @(negedge clk);
        if (bus.val_out) begin
            outs.push_back(int'(bus.o_data));
            pcyc.push_back(cyc);
        end
        if (pend.exists(cyc)) begin
            chk("pulse", longint'(bus.val_out), 1);
            chk("data", longint'(bus.o_data), longint'(pend[cyc]));
            hold = pend[cyc];
            pend.delete(cyc);
        end else begin
            chk("idle_vo", longint'(bus.val_out), 0);
            chk("hold_do", longint'(bus.o_data), longint'(hold));
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) step(1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 65535)) - 32768);
        rst = 1'b1;
        outs.delete();
        pcyc.delete();
    endtask

    task automatic flush();
        repeat (12) step(1'b0, 0);
    endtask

    initial begin
        vec_t tbl [5];
        int   c8;
        int   sgn;
        build_h();
        bus.val_in = 1'b0;
        bus.i_data = '0;

        // Reset held 3 cycles with val_in toggling; outputs stay zero.
        do_reset(3);
        chk("rst_vo", longint'(bus.val_out), 0);
        chk("rst_do", longint'(bus.o_data), 0);
        c8 = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1000);
            if (i == 7) c8 = cyc;
        end
        flush();
        chk("first_lat", (pcyc.size() > 0) ? pcyc[0] : -1, c8 + 6);

        tbl[0] = '{din: 1000,   gap: 1, nout: 8, steady: 1000};
        tbl[1] = '{din: -32768, gap: 1, nout: 6, steady: -32768};
        tbl[2] = '{din: 32767,  gap: 1, nout: 6, steady: 32767};
        tbl[3] = '{din: 1000,   gap: 3, nout: 6, steady: 1000};
        tbl[4] = '{din: -500,   gap: 2, nout: 6, steady: -500};

        foreach (tbl[t]) begin
            do_reset(2);
            for (int i = 0; i < tbl[t].nout * R * tbl[t].gap; i++)
                step(1'((i % tbl[t].gap) == 0), tbl[t].din);
            flush();
            chk("tbl_nout", outs.size(), tbl[t].nout);
            for (int j = 3; j < outs.size(); j++)
                chk("tbl_dc", outs[j], tbl[t].steady);
            for (int j = 1; j < pcyc.size(); j++)
                chk("tbl_gap", pcyc[j] - pcyc[j-1], R * tbl[t].gap);
            if (t == 0) dc_ref = outs;
        end

        // Impulse response: 36, 28, 0, 0.
        do_reset(1);
        step(1'b1, 512);
        repeat (39) step(1'b1, 0);
        flush();
        chk("imp_n", outs.size(), 5);
        if (outs.size() >= 4) begin
            chk("imp0", outs[0], 36);
            chk("imp1", outs[1], 28);
            chk("imp2", outs[2], 0);
            chk("imp3", outs[3], 0);
        end

        // Reset after the 13th input restarts the decimation phase.
        do_reset(1);
        repeat (13) step(1'b1, 1000);
        rst = 1'b0;
        step(1'b1, 1000);
        rst = 1'b1;
        outs.delete();
        repeat (6 * R) step(1'b1, 1000);
        flush();
        chk("mid_n", outs.size(), 6);
        for (int j = 0; j < 6 && j < outs.size(); j++)
            chk("mid_seq", outs[j], dc_ref[j]);

        // Full-scale alternating input, random gaps.
        do_reset(1);
        sgn = 1;
        for (int i = 0; i < 10000; ) begin
            if ($urandom_range(0, 3) != 0) begin
                step(1'b1, sgn * 32767);
                sgn = -sgn;
                i++;
            end else begin
                step(1'b0, 0);
            end
        end
        flush();

        // Random data, random gaps, occasional reset.
        do_reset(1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) rst = 1'b0;
            step(1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 65535)) - 32768);
            rst = 1'b1;
        end
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cic_decim.md
# cic_decim

Three-stage CIC decimation filter. It is the receive-side counterpart of the CIC interpolator:
- Samples at the high input rate are integrated, then decimated by R.
- The result is differentiated by three comb stages at the low rate.
- The full-precision result is truncated to Wout MSBs.

It sits between the high-rate sample source (mixer/ADC path) and the low-rate processing chain, using the same val_in/val_out sample-qualifier convention as the rest of the filter blocks.

## Interface
- Win, 16: input sample width, two's complement.
- Wg, 9: guard bits. Must be ≥ 3·log2(R).
- R, 8: decimation ratio. Power of two, 2..64.
- Wout, 16: output width. Must be ≤ Win+Wg.
- clk  in  1  single clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- val_in  in  1  i_data is valid this cycle. May be asserted every cycle or with arbitrary gaps.
- i_data  in  Win  signed input sample.
- val_out  out  1  one-cycle pulse: o_data is a new decimated sample.
- o_data  out  Wout  signed output, = full-precision result bits [Win+Wg-1 : Win+Wg-Wout].

## Operation
- Internal width: W = Win+Wg. i_data is sign-extended to W. All adds and subtracts are modulo 2^W (wrap-around is required and correct for CIC; no saturation).
- Integrator stage k (k=1..3):
  - On v(k-1): acc_k <= acc_k + d(k-1), and v_k <= 1.
  - Otherwise: v_k <= 0 and acc_k holds.
  - d0 = sign-extended i_data, v0 = val_in; d(k) = acc_k.
- Decimator:
  - Counter cnt, width log2(R), advances only on v3.
  - On v3 with cnt==R-1: dec <= acc_3, vd <= 1, cnt <= 0.
  - On v3 with cnt<R-1: cnt <= cnt+1, vd <= 0.
  - Without v3: vd <= 0, cnt holds.
- Comb stage k (k=1..3), differential delay M=1 low-rate sample:
  - On valid input x: y_k <= x − prev_k, prev_k <= x, valid <= 1.
  - Otherwise valid <= 0 and registers hold.
- Output: o_data = y_3 truncated to its Wout MSBs; val_out = comb-3 valid.
- DC gain = R^3 = 2^(3·log2 R). With Wg = 3·log2(R) and Wout = Win, a DC input reappears unchanged at o_data.
- Reset (rst==0 at a clock edge) clears all accumulators, prev/y registers, dec, cnt and every valid flag. It takes priority over val_in and may occur mid-frame.
  - The first decimated output after reset corresponds to the R-th valid input after reset (decimation phase 0).

## Timing
- Reset values: val_out=0, o_data=0.
- Each stage is registered. Valid propagates one register per stage: 3 integrators + decimator + 3 combs = 7 stages.
- If the R-th valid sample is presented with val_in high in cycle t, val_out is high in cycle t+7 for exactly one cycle.
  - o_data is stable from that cycle until the next val_out pulse.
- Gaps in val_in stretch nothing internally. Samples already in flight still advance one stage per cycle.
- With val_in held continuously high, val_out pulses once every R cycles.
- val_in deasserted: no state change at any stage that does not receive a valid.
- Back-to-back val_in is fully supported. There is no backpressure and no ready signal.

## Test plan
- Reset check: hold rst low 3 cycles with val_in toggling.
  - Required: val_out=0 and o_data=0 throughout.
  - After release, the first val_out comes exactly 7 cycles after the 8th valid input.
- DC: i_data=1000 continuously, val_in=1.
  - Required: val_out every 8 cycles.
  - o_data = 1000 from the 4th output onward (earlier outputs are transients).
  - Repeat the same check with inputs −32768 and 32767.
- Impulse: after reset, i_data=512 on the first valid, then 0 continuously.
  - Required: first three outputs 36, 28, 0, then 0 forever.
- Gapped valid: DC 1000 with val_in asserted on every 3rd cycle.
  - Required: the same output values as the DC test.
  - val_out pulse spacing is 24 cycles, with no spurious pulses.
- Reset mid-operation: DC 1000 streaming, assert rst for 1 cycle after the 13th input.
  - Required: the next output follows the 8th valid input after the reset.
  - The output sequence is identical to the DC test from reset.
- Wrap-around: alternate full-scale ±32767 at every valid for 10,000 inputs.
  - Required: output matches a bit-true modulo-2^25 reference model on every val_out, with no mismatch.
